// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module  : decode_pkg
// Purpose : Shared state and mode encodings for decode_n_scan.
// Rev     : 1.0
// ============================================================================
package decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/decode_n_scan_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module  : onehot_dec
// Purpose : Combinational N-to-2^N one-hot decoder with enable.
// Rev     : 1.0
// ============================================================================
module onehot_dec #(
  parameter int N = 3
) (
  input  logic          en,
  input  logic [N-1:0]  a,
  output logic [2**N-1:0] y
);

  for (genvar i = 0; i < 2**N; i++) begin : g_line
    assign y[i] = en & (a == N'(i));
  end

endmodule
`default_nettype wire

// File: rtl/decode_n_scan.sv
`default_nettype none
// ============================================================================
// Module  : decode_n_scan
// Purpose : Registered one-hot select driver; direct decode via valid/ready
//           or auto-scan through all lines with programmable dwell.
// Rev     : 1.0
// ============================================================================
module decode_n_scan
  import decode_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               En,
  input  logic               mode,
  input  logic               addr_valid,
  input  logic [N-1:0]       addr,
  output logic               addr_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    Y,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int OUTS = 2**N;

  state_e             state_q, state_d;
  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [OUTS-1:0]    y_q, y_d;
  logic               wrap_q, wrap_d;
  logic               xfer;
  logic               scanning;
  logic               advance;
  logic               y_en;

  assign addr_ready = En & (mode == MODE_DIRECT);

  always_comb begin
    if (!En)                    state_d = ST_IDLE;
    else if (mode == MODE_SCAN) state_d = ST_SCAN;
    else                        state_d = ST_DIRECT;

    xfer = addr_valid & addr_ready;
    // Counting only happens while already in scan; the entry edge restarts dwell.
    scanning = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    advance  = scanning && (dwell_cnt_q >= dwell);

    idx_d       = idx_q;
    dwell_cnt_d = '0;
    wrap_d      = 1'b0;
    if (xfer) begin
      idx_d = addr;
    end else if (advance) begin
      idx_d  = idx_q + N'(1);
      wrap_d = &idx_q;
    end else if (scanning) begin
      dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
    end

    y_en = (state_d != ST_IDLE);
  end

  onehot_dec #(
    .N (N)
  ) u_dec (
    .en (y_en),
    .a  (idx_d),
    .y  (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dwell_cnt_q <= '0;
      y_q         <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire
